mm_operand_store: RTL
=====================

// Module: mm_operand_store
// PURPOSE
// - Data side of the matching memory; sits directly after the MMCAM stage and consumes its CAM verdict.
// - Inputs are PACKET, WR_E, DEL and ADDR. First operand of a pair: stores the data word at ADDR.
// - Partner operand: reads the stored word, frees the slot and emits a fired two-operand packet to the firing stage.
// - Non-matching packets (MF=0) bypass as single-operand packets. Synchronous, one clock, valid/ack handshake both sides.
// PARAMETERS
// - TAG_W   18  color/gen/dest field width (PACKET_IN[37:20])
// - DATA_W  18  operand data width (PACKET_IN[17:0])
// - ADDR_W  6   matching-memory address width; DEPTH = 2**ADDR_W = 64
// PORTS
// - CP          in   1      clock, all state on rising edge
// - MR_N        in   1      master reset, synchronous, active-low
// - Send_in     in   1      upstream packet valid
// - Ack_out     out  1      ready to upstream; transfer when Send_in & Ack_out
// - PACKET_IN   in   38     {TAG[37:20], LR[19] (0=L,1=R), MF[18], DATA[17:0]}
// - WR_E        in   1      CAM miss: store operand at ADDR (qualified by Send_in)
// - DEL         in   1      CAM hit: read and free ADDR (qualified by Send_in)
// - ADDR        in   6      matching-memory slot
// - Send_out    out  1      output packet valid
// - Ack_in      in   1      downstream ready; transfer when Send_out & Ack_in
// - PACKET_OUT  out  55     {TAG[54:37], PAIR[36], DATA_L[35:18], DATA_R[17:0]}
// - ERR         out  1      sticky protocol error (write to occupied slot, DEL on empty slot, WR_E&DEL)
// BEHAVIOUR
// - Reset (MR_N=0 at edge): Send_out=0, PACKET_OUT=0, ERR=0, Ack_out=0 in that cycle, occupancy bitmap OCC[63:0]=0, FSM=IDLE. RAM contents are not reset.
// - Reset mid-operation aborts any pending read or output; the packet held in the output register is lost.
// - FSM states:
//   - IDLE: Ack_out = ~out_full. Accepted packet is decoded as follows.
//     - MF=0: load output reg {TAG, PAIR=0, DATA_L=DATA, DATA_R=0}; Send_out next cycle.
//     - MF=1 & WR_E: RAM[ADDR]<=DATA, OCC[ADDR]<=1; no output. Occupied slot sets ERR, data is still overwritten.
//     - MF=1 & DEL (also DEL&WR_E, which sets ERR): latch TAG/LR/DATA; issue RAM read; go to READ.
//     - MF=1 with neither: packet dropped; ERR set.
//   - READ: Ack_out=0. RAM data is valid this cycle (1-cycle sync read). Clear OCC[ADDR]; ERR if OCC was 0.
//     - Build pair: LR=1 gives DATA_L=RAM, DATA_R=latched DATA; LR=0 is swapped. PAIR=1.
//     - Load output reg; go to IDLE.
// - Output reg: one entry; out_full = Send_out & ~Ack_in. PACKET_OUT is stable while Send_out=1 and Ack_in=0.
// - Throughput: 1 packet/cycle for bypass and write. DEL costs 2 cycles.
// - Latency: bypass and write-issue 1 cycle to Send_out; DEL 2 cycles.
// - Hazard: a write at cycle t followed by DEL of the same ADDR at t+1 must return the data written at t.
//   - Implement with RAM write-first or a bypass compare.
// - Simultaneous output acceptance and new input in IDLE is allowed: register drains and reloads in the same cycle.
// CONFIGURATION
// - MM_OPERAND_PARITY_EN defined: RAM width is DATA_W+1 with an even-parity bit written on WR_E.
//   - Parity is checked in READ; a mismatch sets ERR. The packet is still emitted.
// - MM_OPERAND_PARITY_EN undefined: RAM width is DATA_W, no check, and ERR has no parity contribution.
// STRUCTURE
// - Shared header common_macro.vh:
//   - Field widths and packet bit-slice macros: TAG, LR, MF, DATA ranges.
//   - Output-packet layout macros.
//   - FSM state encodings IDLE/READ.
// - Sub-module mm_operand_ram: 64 x (DATA_W[+1]) simple dual-port RAM, one sync write port, one sync read port, write-first.
// - Top holds the FSM, OCC bitmap, output register and ERR logic.
// TESTING
// - Reset: hold MR_N=0 for 2 CP -> Send_out=0, ERR=0, OCC all 0; after release, Ack_out=1.
// - Bypass: MF=0, TAG=0x2A5A5, DATA=0x12345 -> next cycle Send_out=1, PAIR=0, DATA_L=0x12345, DATA_R=0.
// - Pair: WR_E ADDR=5 LR=0 DATA=0x00011, then DEL ADDR=5 LR=1 DATA=0x00022.
//   - Expect 2 cycles later DATA_L=0x11, DATA_R=0x22, PAIR=1, OCC[5]=0.
// - Back-to-back hazard: WR_E ADDR=63 at t, DEL ADDR=63 at t+1 -> returned data equals the data written at t.
// - Backpressure: Ack_in=0 for 5 cycles with the output reg full.
//   - Expect Ack_out=0, PACKET_OUT stable, nothing lost; releasing Ack_in delivers the held packet, then the next.
// - Errors: DEL on empty ADDR=9 -> ERR=1 (sticky until reset).
//   - Under MM_OPERAND_PARITY_EN, force a RAM bit flip -> ERR=1 with the packet still emitted.

Source files
------------

// File: rtl/mm_operand_pkg.sv
// Shared widths, packet field positions and FSM states for the matching-memory operand store.
// MM_OPERAND_PARITY_EN widens the RAM word by one even-parity bit.
package mm_operand_pkg;

    localparam int TAG_W     = 18;
    localparam int DATA_W    = 18;
    localparam int ADDR_W    = 6;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int PKT_IN_W  = TAG_W + 2 + DATA_W;
    localparam int PKT_OUT_W = TAG_W + 1 + 2 * DATA_W;

    // Input packet: {TAG, LR, MF, DATA}
    localparam int IN_DATA_LSB = 0;
    localparam int IN_MF_BIT   = DATA_W;
    localparam int IN_LR_BIT   = DATA_W + 1;
    localparam int IN_TAG_LSB  = DATA_W + 2;

`ifdef MM_OPERAND_PARITY_EN
    localparam int RAM_W = DATA_W + 1;
`else
    localparam int RAM_W = DATA_W;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_e;

    // Output packet: {TAG, PAIR, DATA_L, DATA_R}
    function automatic logic [PKT_OUT_W-1:0] build_out(input logic [TAG_W-1:0]  tag,
                                                       input logic              pair,
                                                       input logic [DATA_W-1:0] data_l,
                                                       input logic [DATA_W-1:0] data_r);
        return {tag, pair, data_l, data_r};
    endfunction

endpackage

// File: rtl/mm_operand_ram.sv
// Simple dual-port operand RAM: one synchronous write port, one synchronous read port.
// A read of the address being written in the same cycle returns the new data.
module mm_operand_ram #(
    parameter int W  = 18,
    parameter int AW = 6
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [1 << AW];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mm_operand_store.sv
// Data side of the matching memory: stores first operands, pairs partners, bypasses singles.
// Build with MM_OPERAND_PARITY_EN to add an even-parity bit per RAM word, checked on read.
module mm_operand_store
    import mm_operand_pkg::*;
(
    input  logic                 CP,
    input  logic                 MR_N,
    input  logic                 Send_in,
    output logic                 Ack_out,
    input  logic [PKT_IN_W-1:0]  PACKET_IN,
    input  logic                 WR_E,
    input  logic                 DEL,
    input  logic [ADDR_W-1:0]    ADDR,
    output logic                 Send_out,
    input  logic                 Ack_in,
    output logic [PKT_OUT_W-1:0] PACKET_OUT,
    output logic                 ERR
);

    state_e                 state_q, state_d;
    logic [DEPTH-1:0]       occ_q, occ_d;
    logic                   send_q, send_d;
    logic [PKT_OUT_W-1:0]   pkt_q, pkt_d;
    logic                   err_q, err_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic                   lr_q, lr_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;

    logic [TAG_W-1:0]       in_tag;
    logic                   in_lr;
    logic                   in_mf;
    logic [DATA_W-1:0]      in_data;
    logic                   ram_we, ram_re;
    logic [RAM_W-1:0]       ram_wdata, ram_rdata;
    logic [DATA_W-1:0]      stored;

    assign in_tag  = PACKET_IN[IN_TAG_LSB +: TAG_W];
    assign in_lr   = PACKET_IN[IN_LR_BIT];
    assign in_mf   = PACKET_IN[IN_MF_BIT];
    assign in_data = PACKET_IN[IN_DATA_LSB +: DATA_W];
    assign stored  = ram_rdata[DATA_W-1:0];

`ifdef MM_OPERAND_PARITY_EN
    assign ram_wdata = {^in_data, in_data};
`else
    assign ram_wdata = in_data;
`endif

    mm_operand_ram #(
        .W  (RAM_W),
        .AW (ADDR_W)
    ) u_ram (
        .clk_i   (CP),
        .we_i    (ram_we),
        .waddr_i (ADDR),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (ADDR),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge CP) begin
        if (!MR_N) begin
            state_q <= ST_IDLE;
            occ_q   <= '0;
            send_q  <= 1'b0;
            pkt_q   <= '0;
            err_q   <= 1'b0;
            tag_q   <= '0;
            lr_q    <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            send_q  <= send_d;
            pkt_q   <= pkt_d;
            err_q   <= err_d;
            tag_q   <= tag_d;
            lr_q    <= lr_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    // The output register drains on Ack_in; a new load in the same cycle overrides the drain.
    always_comb begin
        state_d = state_q;
        occ_d   = occ_q;
        send_d  = send_q & ~Ack_in;
        pkt_d   = pkt_q;
        err_d   = err_q;
        tag_d   = tag_q;
        lr_d    = lr_q;
        data_d  = data_q;
        addr_d  = addr_q;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        Ack_out = 1'b0;

        case (state_q)
            ST_IDLE: begin
                Ack_out = MR_N & ~(send_q & ~Ack_in);
                if (Send_in && Ack_out) begin
                    if (!in_mf) begin
                        send_d = 1'b1;
                        pkt_d  = build_out(in_tag, 1'b0, in_data, '0);
                    end else if (DEL) begin
                        err_d   = err_q | WR_E;
                        tag_d   = in_tag;
                        lr_d    = in_lr;
                        data_d  = in_data;
                        addr_d  = ADDR;
                        ram_re  = 1'b1;
                        state_d = ST_READ;
                    end else if (WR_E) begin
                        ram_we      = 1'b1;
                        err_d       = err_q | occ_q[ADDR];
                        occ_d[ADDR] = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                // Entering READ required an empty or draining output register, so it is free now.
                occ_d[addr_q] = 1'b0;
                err_d         = err_q | ~occ_q[addr_q];
`ifdef MM_OPERAND_PARITY_EN
                err_d         = err_d | (^ram_rdata);
`endif
                send_d  = 1'b1;
                pkt_d   = lr_q ? build_out(tag_q, 1'b1, stored, data_q)
                               : build_out(tag_q, 1'b1, data_q, stored);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign Send_out   = send_q;
    assign PACKET_OUT = pkt_q;
    assign ERR        = err_q;

endmodule
